// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART blocks.
//   - register word addresses (bus data_addr[3:2])
//   - status word bit positions
//   - transmitter FSM state encoding
package uart_pkg;

  localparam logic [1:0] UART_TX_DATA = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_CTRL    = 2'd2;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO, shared by the TX and RX paths.
// Ports:
//   clk, resetn      clock, async active-low reset
//   push, wdata      write request / data (ignored when full unless popping)
//   pop              read request (ignored when empty); rdata shows the head
//   flush            empties the FIFO on the next edge; wins over push
//   full, empty      occupancy flags
//   count            entries held, $clog2(DEPTH)+1 bits
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read before it is written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: memory-mapped 8N1 UART transmitter with a byte FIFO.
// Ports:
//   clk, resetn   clock, async active-low reset
//   wen, ren      bus write / read strobes (one cycle per access)
//   address       word select: 0 data(wo), 1 status(ro), 2 ctrl(rw), 3 reserved
//   data_in       write data, [7:0] pushed, [0] flush on ctrl
//   data_out      registered read data, updated only on ren
//   uart_tx       serial line, idles high
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wen,
  input  logic        ren,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        uart_tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  // Bus decode
  logic push_req, flush_req, stat_rd;
  assign push_req  = wen && (address == UART_TX_DATA);
  assign flush_req = wen && (address == UART_CTRL) && data_in[0];
  assign stat_rd   = ren && (address == UART_STATUS);

  logic unused_data_hi;
  assign unused_data_hi = ^data_in[31:8];

  // FIFO
  logic          fifo_pop, full, empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] count;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_req),
    .pop    (fifo_pop),
    .flush  (flush_req),
    .wdata  (data_in[7:0]),
    .rdata  (fifo_rdata),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  // Transmitter FSM
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d, baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      uart_tx <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      uart_tx <= tx_d;
    end
  end

  // tx_d is decoded from the current state and registered, so the line
  // trails the state by one cycle and never glitches.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx_d     = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[bit_q];
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Overflow flag and read mux
  logic        ovf_q, ovf_set;
  logic [31:0] rd_word;

  // A pushed byte is lost only when full with no pop making room; a flush
  // discards it anyway, so that is not counted as an overflow.
  assign ovf_set = push_req && full && !fifo_pop && !flush_req;

  always_comb begin
    rd_word = '0;
    if (address == UART_STATUS) begin
      rd_word[ST_EMPTY]                 = empty;
      rd_word[ST_FULL]                  = full;
      rd_word[ST_BUSY]                  = (state_q != IDLE);
      rd_word[ST_OVF]                   = ovf_q;
      rd_word[ST_CNT_LSB+7:ST_CNT_LSB]  = 8'(count);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q    <= 1'b0;
      data_out <= '0;
    end else begin
      // A fresh overflow beats the clear-on-read.
      ovf_q <= ovf_set || (ovf_q && !stat_rd);
      if (ren) data_out <= rd_word;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
module tb_uart_tx_buffer;

  localparam int CPB    = 4;
  localparam int DEPTH  = 4;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = CPB * CLK_NS;
  localparam int SLOT   = 10 * CPB + 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  always #(CLK_NS/2) clk = ~clk;

  uart_tx_buffer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wen      (wen),
    .ren      (ren),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .uart_tx  (uart_tx)
  );

  // Line monitor: decodes 8N1 frames by sampling near each bit centre.
  typedef struct {
    logic [7:0] data;
    logic       start_bit;
    logic       stop_bit;
    longint     t;
  } frame_t;

  frame_t rx_q[$];
  int     fall_cnt = 0;
  longint last_t = 0;

  initial begin : mon
    frame_t f;
    forever begin
      @(negedge uart_tx);
      f.t = $time;
      #(BIT_NS/2 - CLK_NS/2);
      f.start_bit = uart_tx;
      for (int i = 0; i < 8; i++) begin
        #(BIT_NS);
        f.data[i] = uart_tx;
      end
      #(BIT_NS);
      f.stop_bit = uart_tx;
      rx_q.push_back(f);
    end
  end

  initial begin : falls
    forever begin
      @(negedge uart_tx);
      fall_cnt++;
    end
  end

  initial begin : watchdog
    #(CLK_NS * 50000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Drives one bus cycle; returns 1 ns after the sampling edge.
  task automatic bus(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
    wen = w; ren = r; address = a; data_in = d;
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bus(1'b1, 1'b0, 2'd0, {24'h0, b});
  endtask

  task automatic rd_status(input string nm, input logic [31:0] exp);
    bus(1'b0, 1'b1, 2'd1, 32'h0);
    chk(nm, data_out, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_frames(input string nm, input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk(nm, 32'(rx_q.size()), 32'(n));
  endtask

  task automatic chk_frame(input string nm, input logic [7:0] exp);
    frame_t f;
    if (rx_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no frame want 0x%02h", nm, exp);
    end else begin
      f = rx_q.pop_front();
      last_t = f.t;
      chk(nm, {22'h0, f.stop_bit, f.start_bit, f.data}, {22'h0, 2'b10, exp});
    end
  endtask

  task automatic idle_high(input string nm, input int n);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk(nm, 32'(lows), 32'h0);
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic        w;
    logic        r;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  vec_t vt[12];

  initial begin
    longint t1, t2;
    int     f0;

    // Register-access vectors from the reset/idle state (every entry reads).
    vt[0]  = {1'b0, 1'b1, 2'd1, 32'h0000_0000, 32'h0000_0001};
    vt[1]  = {1'b0, 1'b1, 2'd0, 32'h0000_0000, 32'h0000_0000};
    vt[2]  = {1'b0, 1'b1, 2'd2, 32'h0000_0000, 32'h0000_0000};
    vt[3]  = {1'b0, 1'b1, 2'd3, 32'h0000_0000, 32'h0000_0000};
    vt[4]  = {1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[5]  = {1'b0, 1'b1, 2'd1, 32'h0000_0000, 32'h0000_0001};
    vt[6]  = {1'b1, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'h0000_0000};
    vt[7]  = {1'b0, 1'b1, 2'd1, 32'h0000_0000, 32'h0000_0001};
    vt[8]  = {1'b1, 1'b1, 2'd2, 32'h0000_0001, 32'h0000_0000};
    vt[9]  = {1'b0, 1'b1, 2'd1, 32'h0000_0000, 32'h0000_0001};
    vt[10] = {1'b1, 1'b1, 2'd1, 32'h0000_FFFF, 32'h0000_0001};
    vt[11] = {1'b0, 1'b1, 2'd1, 32'h0000_0000, 32'h0000_0001};

    // Reset
    cycles(5);
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_tx", {31'h0, uart_tx}, 32'h1);
    resetn = 1'b1;
    cycles(1);

    idle_high("idle50", 50);

    for (int i = 0; i < 12; i++) begin
      bus(vt[i].w, vt[i].r, vt[i].a, vt[i].d);
      chk($sformatf("vec%0d", i), data_out, vt[i].e);
    end
    cycles(5);
    chk("data_out_hold", data_out, 32'h0000_0001);

    // Single byte: latency, frame content, busy during and after.
    push(8'hA5);
    chk("a5_tx_n0", {31'h0, uart_tx}, 32'h1);
    @(posedge clk); #1;
    chk("a5_tx_n1", {31'h0, uart_tx}, 32'h1);
    @(posedge clk); #1;
    chk("a5_tx_n2", {31'h0, uart_tx}, 32'h0);
    rd_status("a5_busy", 32'h0000_0005);
    wait_frames("a5_wait", 1, 60);
    chk_frame("a5_frame", 8'hA5);
    cycles(5);
    rd_status("a5_done", 32'h0000_0001);

    // Back-to-back bytes: order and frame spacing.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    rd_status("b2b_count", 32'h0000_0204);
    wait_frames("b2b_wait", 3, 3 * SLOT + 20);
    chk_frame("b2b_f0", 8'h01);
    t1 = last_t;
    chk_frame("b2b_f1", 8'h02);
    t2 = last_t;
    chk("b2b_gap01", 32'(t2 - t1), 32'(SLOT * CLK_NS));
    chk_frame("b2b_f2", 8'h03);
    chk("b2b_gap12", 32'(last_t - t2), 32'(SLOT * CLK_NS));
    cycles(5);

    // Overflow: six pushes in six cycles, one is dropped.
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    rd_status("ovf_first", 32'h0000_040E);
    rd_status("ovf_second", 32'h0000_0406);
    wait_frames("ovf_wait", 5, 5 * SLOT + 20);
    for (int i = 0; i < 5; i++) chk_frame($sformatf("ovf_f%0d", i), 8'h10 + 8'(i));
    idle_high("ovf_no6th", 60);
    chk("ovf_extra", 32'(rx_q.size()), 32'h0);
    rd_status("ovf_idle", 32'h0000_0001);

    // Mid-frame flush with three queued bytes.
    for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
    cycles(10);
    bus(1'b1, 1'b0, 2'd2, 32'h0000_0001);
    rd_status("flush_status", 32'h0000_0005);
    wait_frames("flush_wait", 1, SLOT + 20);
    chk_frame("flush_f0", 8'h31);
    idle_high("flush_quiet", 100);
    chk("flush_extra", 32'(rx_q.size()), 32'h0);
    rd_status("flush_idle", 32'h0000_0001);

    // Reset during DATA bit 3.
    push(8'hF0);
    push(8'h77);
    push(8'h66);
    cycles(17);
    chk("rst_bit3", {31'h0, uart_tx}, 32'h0);
    resetn = 1'b0;
    #1;
    chk("rst_tx_high", {31'h0, uart_tx}, 32'h1);
    cycles(3);
    resetn = 1'b1;
    cycles(1);
    rd_status("rst_status", 32'h0000_0001);
    f0 = fall_cnt;
    idle_high("rst_quiet", 100);
    chk("rst_no_frame", 32'(fall_cnt - f0), 32'h0);
    rx_q.delete();

    // Randomised traffic against an ideal in-order byte queue.
    for (int r = 0; r < 8; r++) begin
      int         n;
      logic [7:0] exp_q[$];
      logic [7:0] b;
      logic [31:0] rv;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        b  = 8'($urandom);
        rv = $urandom;
        case ($urandom_range(0, 2))
          0: bus(1'b1, 1'b0, 2'd3, rv);
          1: bus(1'b1, 1'b0, 2'd2, rv & 32'hFFFF_FFFE);
          default: ;
        endcase
        push(b);
        exp_q.push_back(b);
        cycles($urandom_range(0, 3));
      end
      wait_frames($sformatf("rnd%0d_wait", r), n, n * (SLOT + 4) + 20);
      while (exp_q.size() > 0) chk_frame($sformatf("rnd%0d_frame", r), exp_q.pop_front());
      cycles(5);
      rd_status($sformatf("rnd%0d_idle", r), 32'h0000_0001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
